// File: rtl/delay_diff_prog.sv
// delay_diff_prog: multi-channel x[n] - x[n-D] differencer, D runtime-selectable and counted in valid samples.
// Define DELAY_DIFF_PROG_SAT_EN to saturate the difference and drive sat_flags; otherwise it wraps.
module delay_diff_prog #(
    parameter int unsigned NUM_CHANNELS  = 16,
    parameter int unsigned DATA_WIDTH    = 20,
    parameter int unsigned MAX_DELAY     = 16,
    parameter int unsigned DEFAULT_DELAY = 2,
    localparam int unsigned DSW          = $clog2(MAX_DELAY + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [DSW-1:0]                     delay_sel,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] diff_out,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_before_diff_out,
    output logic                               valid_out,
    output logic                               primed,
    output logic [NUM_CHANNELS-1:0]            sat_flags
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned BW = NUM_CHANNELS * DATA_WIDTH;
    localparam int unsigned PW = $clog2(MAX_DELAY);
    localparam int unsigned SW = DSW + 1;

    logic [BW-1:0]           data_q;
    logic                    valid_q;
    logic [DSW-1:0]          dsel_q;
    logic                    chg_q;
    logic [DSW-1:0]          dsel_clamp_c;

    logic [BW-1:0]           mem [MAX_DELAY];
    logic [PW-1:0]           wr_ptr;
    logic [DSW-1:0]          fill_cnt;
    logic [SW-1:0]           rd_sum_c;
    logic [PW-1:0]           rd_ptr_c;
    logic [BW-1:0]           rd_data_c;
    logic [BW-1:0]           diff_c;
    logic [NUM_CHANNELS-1:0] sat_c;
    logic                    enough_c;

    // Clamp the requested delay into 1..MAX_DELAY
    always_comb begin
        dsel_clamp_c = delay_sel;
        if (delay_sel == '0) begin
            dsel_clamp_c = DSW'(1);
        end else if (delay_sel > DSW'(MAX_DELAY)) begin
            dsel_clamp_c = DSW'(MAX_DELAY);
        end
    end

    // Stage 0: input capture and delay-change detection
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            dsel_q  <= DSW'(DEFAULT_DELAY);
            chg_q   <= 1'b0;
        end else begin
            data_q  <= data_in;
            valid_q <= valid_in;
            dsel_q  <= dsel_clamp_c;
            chg_q   <= (dsel_clamp_c != dsel_q);
        end
    end

    // Read slot is D behind the write pointer, modulo the buffer depth
    always_comb begin
        rd_sum_c = SW'(wr_ptr) + SW'(MAX_DELAY) - SW'(dsel_q);
        if (rd_sum_c >= SW'(MAX_DELAY)) begin
            rd_sum_c = rd_sum_c - SW'(MAX_DELAY);
        end
        rd_ptr_c  = PW'(rd_sum_c);
        rd_data_c = mem[rd_ptr_c];
        enough_c  = (fill_cnt >= dsel_q) && !chg_q;
    end

    // Per-channel subtraction, exact at DW+1 bits before reduction
    always_comb begin
        diff_c = '0;
        sat_c  = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
`ifdef DELAY_DIFF_PROG_SAT_EN
            logic [DW:0] full;
            full = {data_q[j*DW + DW - 1], data_q[j*DW +: DW]}
                 - {rd_data_c[j*DW + DW - 1], rd_data_c[j*DW +: DW]};
            if (full[DW] != full[DW-1]) begin
                diff_c[j*DW +: DW] = full[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
                sat_c[j]           = 1'b1;
            end else begin
                diff_c[j*DW +: DW] = full[DW-1:0];
            end
`else
            diff_c[j*DW +: DW] = data_q[j*DW +: DW] - rd_data_c[j*DW +: DW];
`endif
        end
    end

    // Sample buffer: read-before-write, contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && valid_q) begin
            mem[wr_ptr] <= data_q;
        end
    end

    // Stage 1: pointer/fill bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr               <= '0;
            fill_cnt             <= '0;
            valid_out            <= 1'b0;
            primed               <= 1'b0;
            diff_out             <= '0;
            data_before_diff_out <= '0;
            sat_flags            <= '0;
        end else begin
            if (chg_q) begin
                fill_cnt <= valid_q ? DSW'(1) : '0;
            end else if (valid_q && (fill_cnt < DSW'(MAX_DELAY))) begin
                fill_cnt <= fill_cnt + DSW'(1);
            end
            primed    <= enough_c;
            valid_out <= valid_q && enough_c;
            if (valid_q) begin
                wr_ptr               <= (wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr + PW'(1);
                diff_out             <= diff_c;
                data_before_diff_out <= data_q;
                sat_flags            <= sat_c;
            end
        end
    end

endmodule
